// File: rtl/temp_conv_rom_arbiter_pkg.sv
// Shared types and constants for the two-requester temperature-conversion ROM arbiter.
package temp_conv_pkg;

  localparam int TEMP_WIDTH = 8;

  localparam logic UNIT_C_TO_F = 1'b0;
  localparam logic UNIT_F_TO_C = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/temp_conv_rom_arbiter_if.sv
// Request/response bundle between the two conversion clients and the ROM arbiter.
// Handshake rule for every channel: a transfer happens on a rising edge where valid and
// ready are both high; the valid side holds its payload stable until that edge.
interface temp_conv_rom_arbiter_if #(
  parameter int DATA_WIDTH = temp_conv_pkg::TEMP_WIDTH
);
  logic                  req0_valid_i;
  logic                  req0_ready_o;
  logic [DATA_WIDTH-1:0] req0_temp_i;
  logic                  req0_unit_i;
  logic                  req1_valid_i;
  logic                  req1_ready_o;
  logic [DATA_WIDTH-1:0] req1_temp_i;
  logic                  req1_unit_i;
  logic                  rsp0_valid_o;
  logic                  rsp0_ready_i;
  logic [DATA_WIDTH-1:0] rsp0_temp_o;
  logic                  rsp1_valid_o;
  logic                  rsp1_ready_i;
  logic [DATA_WIDTH-1:0] rsp1_temp_o;

  modport master (
    output req0_valid_i, req0_temp_i, req0_unit_i,
    output req1_valid_i, req1_temp_i, req1_unit_i,
    output rsp0_ready_i, rsp1_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp0_temp_o, rsp1_valid_o, rsp1_temp_o
  );

  modport slave (
    input  req0_valid_i, req0_temp_i, req0_unit_i,
    input  req1_valid_i, req1_temp_i, req1_unit_i,
    input  rsp0_ready_i, rsp1_ready_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp0_temp_o, rsp1_valid_o, rsp1_temp_o
  );

endinterface

// File: rtl/temp_conv_rom_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin pick; ptr names the requester favoured on a tie.
module rr_arbiter_2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = {valid1, valid0};
    end
  end

endmodule

// File: rtl/temp_conv_rom_arbiter.sv
// Round-robin sharing of one synchronous conversion ROM between two requesters.
// Define TEMP_CONV_ARB_STATS_EN to add saturating per-requester grant counters.
module temp_conv_rom_arbiter
  import temp_conv_pkg::*;
#(
  parameter  int DATA_WIDTH     = TEMP_WIDTH,
  parameter  int ROM_LATENCY    = 1,
  localparam int ROM_ADDR_WIDTH = DATA_WIDTH + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  temp_conv_rom_arbiter_if.slave    bus,
  output logic                      rom_en_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0]     rom_data_i,
  output logic                      busy_o,
  output state_t                    state_o
`ifdef TEMP_CONV_ARB_STATS_EN
  ,
  output logic [15:0]               grant_cnt0_o,
  output logic [15:0]               grant_cnt1_o
`endif
);

  localparam logic [1:0] WAIT_INIT = 2'(ROM_LATENCY - 1);

  state_t                    state_q, state_d;
  logic [1:0]                grant;
  logic                      ptr_q;
  logic                      owner_q;
  logic [1:0]                wait_q;
  logic [ROM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     temp0_q, temp1_q;
  logic                      idle, hs0, hs1, rsp_hs;

  rr_arbiter_2 u_arb (
    .valid0 (bus.req0_valid_i),
    .valid1 (bus.req1_valid_i),
    .ptr    (ptr_q),
    .grant  (grant)
  );

  // Readies are gated by reset so nothing can be accepted while rst_ni is low.
  assign idle   = rst_ni && (state_q == IDLE);
  assign hs0    = bus.req0_valid_i && idle && grant[0];
  assign hs1    = bus.req1_valid_i && idle && grant[1];
  assign rsp_hs = (state_q == RESP) && (owner_q ? bus.rsp1_ready_i : bus.rsp0_ready_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs0 || hs1) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_q == 2'd0) state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      wait_q  <= 2'd0;
      addr_q  <= '0;
      temp0_q <= '0;
      temp1_q <= '0;
    end else begin
      if (hs0) begin
        addr_q  <= {bus.req0_unit_i, bus.req0_temp_i};
        owner_q <= 1'b0;
      end else if (hs1) begin
        addr_q  <= {bus.req1_unit_i, bus.req1_temp_i};
        owner_q <= 1'b1;
      end
      if (state_q == ISSUE) begin
        wait_q <= WAIT_INIT;
      end else if (state_q == WAIT && wait_q != 2'd0) begin
        wait_q <= wait_q - 2'd1;
      end
      // Last WAIT cycle is exactly ROM_LATENCY edges after the strobe.
      if (state_q == WAIT && wait_q == 2'd0) begin
        if (owner_q) temp1_q <= rom_data_i;
        else         temp0_q <= rom_data_i;
      end
      if (rsp_hs) begin
        ptr_q <= ~owner_q;
      end
    end
  end

  always_comb begin
    bus.req0_ready_o = idle && grant[0];
    bus.req1_ready_o = idle && grant[1];
    bus.rsp0_valid_o = (state_q == RESP) && !owner_q;
    bus.rsp1_valid_o = (state_q == RESP) && owner_q;
    rom_en_o         = (state_q == ISSUE);
    busy_o           = (state_q != IDLE);
    state_o          = state_q;
  end

  assign rom_addr_o      = addr_q;
  assign bus.rsp0_temp_o = temp0_q;
  assign bus.rsp1_temp_o = temp1_q;

`ifdef TEMP_CONV_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      grant_cnt0_o <= 16'd0;
      grant_cnt1_o <= 16'd0;
    end else begin
      if (hs0 && grant_cnt0_o != 16'hFFFF) grant_cnt0_o <= grant_cnt0_o + 16'd1;
      if (hs1 && grant_cnt1_o != 16'hFFFF) grant_cnt1_o <= grant_cnt1_o + 16'd1;
    end
  end
`endif

endmodule
